// File: rtl/wb_fir_bridge.sv
// -----------------------------------------------------------------------------
// wb_fir_bridge
//
// Wishbone slave for the 0x3000_xxxx user-project window. It turns CPU
// accesses into FIR engine transfers:
//   offset 0x000-0x07F : AXI-Lite read/write (configuration and tap registers)
//   offset 0x080 write : AXI-Stream push of one X sample (ss_*)
//   offset 0x084 read  : AXI-Stream pop of one Y sample (sm_*)
//   anything else      : unmapped, acked at once (read data 0, write dropped)
// ss_tlast is generated from a shadow copy of the data-length register
// (Lite offset 0x010) and a push counter cleared by ap_start (0x000 bit 0).
// Any handshake that stalls for TIMEOUT cycles is aborted and acked, with
// ERR_DATA returned for reads.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_*                     Wishbone slave (ack/dat registered, dat 0 when
//                             ack is low; sel is ignored)
//   aw*/w*/ar*/r*             AXI-Lite master channels (no B channel)
//   ss_*                      AXI-Stream master towards the FIR (X samples)
//   sm_*                      AXI-Stream slave from the FIR (Y samples)
// -----------------------------------------------------------------------------
module wb_fir_bridge #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [11:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic        wvalid,
   input  logic        wready,
   output logic [11:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] ss_tdata,
   output logic        ss_tvalid,
   output logic        ss_tlast,
   input  logic        ss_tready,
   input  logic [31:0] sm_tdata,
   input  logic        sm_tvalid,
   input  logic        sm_tlast,
   output logic        sm_tready
);

   // Wide enough to count up to TIMEOUT-1, the last value before abort.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LW,
      LR_A,
      LR_D,
      SPUSH,
      SPOP,
      ACK
   } state_t;

   state_t        state_q, state_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          ssTvalid_q, ssTvalid_d;
   logic          smTready_q, smTready_d;
   logic          awDone_q, awDone_d;
   logic          wDone_q, wDone_d;
   logic [11:0]   awaddr_q, awaddr_d;
   logic [11:0]   araddr_q, araddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   ssTdata_q, ssTdata_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic [CW-1:0] waitCnt_q, waitCnt_d;
   logic [31:0]   len_q, len_d;
   logic [31:0]   pushCnt_q, pushCnt_d;

   logic [11:0] offset;
   logic        req, isLite, isPush, isPop;
   logic        awHs, wHs, arHs, rHs, pushHs, popHs, timeUp;
   logic        unusedInputs;

   assign unusedInputs = ^{wbs_sel_i, wbs_adr_i[23:12], sm_tlast};

   assign offset = wbs_adr_i[11:0];
   assign req    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == 8'h30);
   assign isLite = (offset < 12'h080);
   assign isPush = (offset == 12'h080) & wbs_we_i;
   assign isPop  = (offset == 12'h084) & ~wbs_we_i;

   // Handshakes are judged from the registered valids/readies, so each one
   // completes on the edge where both sides are seen high.
   assign awHs   = awvalid_q & awready;
   assign wHs    = wvalid_q & wready;
   assign arHs   = arvalid_q & arready;
   assign rHs    = rready_q & rvalid;
   assign pushHs = ssTvalid_q & ss_tready;
   assign popHs  = smTready_q & sm_tvalid;
   assign timeUp = (waitCnt_q == CW'(TIMEOUT - 1));

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign awaddr    = awaddr_q;
   assign awvalid   = awvalid_q;
   assign wdata     = wdata_q;
   assign wvalid    = wvalid_q;
   assign araddr    = araddr_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign ss_tdata  = ssTdata_q;
   assign ss_tvalid = ssTvalid_q;
   assign sm_tready = smTready_q;
   assign ss_tlast  = (len_q != 32'd0) & (pushCnt_q == (len_q - 32'd1));

   // Next-state logic for the transaction FSM. Every path into ACK sets
   // ack_d together with the read data, so ack and data rise on the same edge;
   // ACK itself clears both on the way back to IDLE.
   always_comb begin
      state_d    = state_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      ssTvalid_d = ssTvalid_q;
      smTready_d = smTready_q;
      awDone_d   = awDone_q;
      wDone_d    = wDone_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      ssTdata_d  = ssTdata_q;
      ack_d      = 1'b0;
      dat_d      = dat_q;
      waitCnt_d  = waitCnt_q;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               waitCnt_d = '0;
               if (isLite && wbs_we_i) begin
                  state_d   = LW;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awDone_d  = 1'b0;
                  wDone_d   = 1'b0;
                  awaddr_d  = offset;
                  wdata_d   = wbs_dat_i;
               end else if (isLite) begin
                  state_d   = LR_A;
                  arvalid_d = 1'b1;
                  araddr_d  = offset;
               end else if (isPush) begin
                  state_d    = SPUSH;
                  ssTvalid_d = 1'b1;
                  ssTdata_d  = wbs_dat_i;
               end else if (isPop) begin
                  state_d    = SPOP;
                  smTready_d = 1'b1;
               end else begin
                  state_d = ACK;
                  ack_d   = 1'b1;
                  dat_d   = 32'd0;
               end
            end
         end

         LW: begin
            awDone_d = awDone_q | awHs;
            wDone_d  = wDone_q | wHs;
            if (awHs) awvalid_d = 1'b0;
            if (wHs)  wvalid_d  = 1'b0;
            if ((awDone_q | awHs) && (wDone_q | wHs)) begin
               state_d = ACK;
               ack_d   = 1'b1;
               dat_d   = 32'd0;
            end else if (timeUp) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
               state_d   = ACK;
               ack_d     = 1'b1;
               dat_d     = 32'd0;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
         end

         LR_A: begin
            if (arHs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               waitCnt_d = '0;
               state_d   = LR_D;
            end else if (timeUp) begin
               arvalid_d = 1'b0;
               state_d   = ACK;
               ack_d     = 1'b1;
               dat_d     = ERR_DATA;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
         end

         LR_D: begin
            if (rHs) begin
               rready_d = 1'b0;
               state_d  = ACK;
               ack_d    = 1'b1;
               dat_d    = rdata;
            end else if (timeUp) begin
               rready_d = 1'b0;
               state_d  = ACK;
               ack_d    = 1'b1;
               dat_d    = ERR_DATA;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
         end

         SPUSH: begin
            if (pushHs || timeUp) begin
               ssTvalid_d = 1'b0;
               state_d    = ACK;
               ack_d      = 1'b1;
               dat_d      = 32'd0;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
         end

         SPOP: begin
            if (popHs) begin
               smTready_d = 1'b0;
               state_d    = ACK;
               ack_d      = 1'b1;
               dat_d      = sm_tdata;
            end else if (timeUp) begin
               smTready_d = 1'b0;
               state_d    = ACK;
               ack_d      = 1'b1;
               dat_d      = ERR_DATA;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
         end

         ACK: begin
            state_d = IDLE;
            dat_d   = 32'd0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shadow length and push counter. Both follow the W handshake of the
   // Lite write, using the registered address/data of that transaction. An
   // aborted push never handshakes, so the counter only moves on real pushes.
   always_comb begin
      len_d     = len_q;
      pushCnt_d = pushCnt_q;
      if (wHs && (awaddr_q == 12'h010)) begin
         len_d = wdata_q;
      end
      if (wHs && (awaddr_q == 12'h000) && wdata_q[0]) begin
         pushCnt_d = 32'd0;
      end else if (pushHs) begin
         pushCnt_d = ss_tlast ? 32'd0 : (pushCnt_q + 32'd1);
      end
   end

   // State and output registers; reset drops every output at once, which
   // also abandons any transaction in flight without an acknowledge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         ssTvalid_q <= 1'b0;
         smTready_q <= 1'b0;
         awDone_q   <= 1'b0;
         wDone_q    <= 1'b0;
         awaddr_q   <= 12'd0;
         araddr_q   <= 12'd0;
         wdata_q    <= 32'd0;
         ssTdata_q  <= 32'd0;
         ack_q      <= 1'b0;
         dat_q      <= 32'd0;
         waitCnt_q  <= '0;
         len_q      <= 32'd0;
         pushCnt_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         ssTvalid_q <= ssTvalid_d;
         smTready_q <= smTready_d;
         awDone_q   <= awDone_d;
         wDone_q    <= wDone_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         ssTdata_q  <= ssTdata_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         waitCnt_q  <= waitCnt_d;
         len_q      <= len_d;
         pushCnt_q  <= pushCnt_d;
      end
   end

endmodule

// File: tb/tb_wb_fir_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_fir_bridge
//
// Directed bench for wb_fir_bridge. A small AXI-Lite slave (32-word memory
// with programmable ready/valid delays) and stream responders sit around the
// bridge; a Wishbone master task issues single accesses and measures the
// number of clock edges from the request-sample edge to the ack cycle.
// -----------------------------------------------------------------------------
module tb_wb_fir_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [11:0] awaddr, araddr;
   logic        awvalid, wvalid, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] wdata;
   logic [31:0] rdata = 32'd0;
   logic [31:0] ss_tdata;
   logic        ss_tvalid, ss_tlast;
   logic        ss_tready = 1'b0;
   logic [31:0] smData = 32'd0;
   logic        smValid = 1'b0;
   logic        sm_tready;

   int compared = 0;
   int mismatched = 0;

   // Responder controls and observation state.
   int          awDelay = 0, wDelay = 0, arDelay = 0, rDelay = 0;
   int          awWait = 0, wWait = 0, arWait = 0, rWait = 0;
   logic [31:0] mem [32];
   logic [11:0] capAw = 12'd0, lastAwaddr = 12'd0;
   logic [31:0] capW = 32'd0;
   bit          awPend = 0, wPend = 0;
   int          awCycles = 0, wCycles = 0, axiActivity = 0;
   int          pushIdx = 0;
   logic [31:0] pushData [8];
   logic        pushLast [8];
   logic        lastSmTready;

   logic [127:0] allOut;
   assign allOut = {wbs_ack_o, wbs_dat_o, awaddr, araddr, awvalid, wvalid, arvalid,
                    rready, wdata, ss_tdata, ss_tvalid, ss_tlast, sm_tready};

   wb_fir_bridge dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wready    (wready),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rready    (rready),
      .ss_tdata  (ss_tdata),
      .ss_tvalid (ss_tvalid),
      .ss_tlast  (ss_tlast),
      .ss_tready (ss_tready),
      .sm_tdata  (smData),
      .sm_tvalid (smValid),
      .sm_tlast  (1'b0),
      .sm_tready (sm_tready)
   );

   always #5 clk = ~clk;

   // Ready/valid responders, driven on the falling edge so the bridge sees
   // stable inputs at each rising edge. A delay of N holds ready low for N
   // falling edges after the bridge raises its valid (or rready).
   always @(negedge clk) begin
      if (awvalid) begin awready = (awWait >= awDelay); awWait++; end
      else begin awready = 1'b0; awWait = 0; end
      if (wvalid) begin wready = (wWait >= wDelay); wWait++; end
      else begin wready = 1'b0; wWait = 0; end
      if (arvalid) begin arready = (arWait >= arDelay); arWait++; end
      else begin arready = 1'b0; arWait = 0; end
      if (rready) begin rvalid = (rWait >= rDelay); rWait++; end
      else begin rvalid = 1'b0; rWait = 0; end
      ss_tready = ss_tvalid;
   end

   // Slave-side capture at the rising edge, using pre-edge values.
   always @(posedge clk) begin
      if (awvalid) awCycles++;
      if (wvalid)  wCycles++;
      if (awvalid || wvalid || arvalid || rready || ss_tvalid || sm_tready) axiActivity++;
      if (awvalid && awready) begin capAw = awaddr; lastAwaddr = awaddr; awPend = 1; end
      if (wvalid && wready) begin capW = wdata; wPend = 1; end
      if (awPend && wPend) begin
         mem[capAw[6:2]] = capW;
         awPend = 0;
         wPend = 0;
      end
      if (arvalid && arready) rdata = mem[araddr[6:2]];
      if (ss_tvalid && ss_tready && pushIdx < 8) begin
         pushData[pushIdx] = ss_tdata;
         pushLast[pushIdx] = ss_tlast;
         pushIdx++;
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // One Wishbone access. lat counts rising edges from the request-sample
   // edge (counted as 1) up to the edge after which ack is visible.
   task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input int maxCycles, output logic [31:0] rdat,
                                output int lat, output bit seen);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = wr; adr = a; wdat = d;
      seen = 0; lat = 0; rdat = 32'd0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (wbs_ack_o) begin
            seen = 1;
            rdat = wbs_dat_o;
            lastSmTready = sm_tready;
         end
      end
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      if (seen) begin
         @(posedge clk); #1;
         checkOutput($sformatf("ackDrop@%0h", a), {wbs_ack_o, wbs_dat_o}, 33'd0);
      end
   endtask

   logic [31:0] rd;
   int          lat;
   bit          seen;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      mem[0] = 32'h4;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("resetState", allOut, 128'd0);
      rst = 1'b0;

      // Reset in the middle of a stalled Lite write.
      awDelay = 100;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0020; wdat = 32'h55;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("lwAwvalidHigh", {127'd0, awvalid}, 128'd1);
      #2 rst = 1'b1;
      #1 checkOutput("rstMidLw", allOut, 128'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      awDelay = 0;

      // Read after reset, immediate slave.
      applyStimulus(1'b0, 32'h3000_0000, 32'd0, 50, rd, lat, seen);
      checkOutput("rdAfterRst.data", rd, 32'h4);
      checkOutput("rdAfterRst.lat", lat, 3);

      // Write len=64 with awready 3 cycles late.
      awDelay = 3; awCycles = 0; wCycles = 0;
      applyStimulus(1'b1, 32'h3000_0010, 32'd64, 50, rd, lat, seen);
      checkOutput("wrLen.lat", lat, 5);
      checkOutput("wrLen.wvalidCycles", wCycles, 1);
      checkOutput("wrLen.awvalidCycles", awCycles, 4);
      checkOutput("wrLen.awaddr", lastAwaddr, 12'h010);
      awDelay = 0;
      applyStimulus(1'b0, 32'h3000_0010, 32'd0, 50, rd, lat, seen);
      checkOutput("rdLen.data", rd, 32'd64);

      // Read with rvalid two cycles after rready.
      rDelay = 2;
      applyStimulus(1'b0, 32'h3000_0000, 32'd0, 50, rd, lat, seen);
      checkOutput("rdSlow.data", rd, 32'h4);
      checkOutput("rdSlow.lat", lat, 5);
      rDelay = 0;

      // tlast generation: len=3, ap_start, four pushes.
      applyStimulus(1'b1, 32'h3000_0010, 32'd3, 50, rd, lat, seen);
      applyStimulus(1'b1, 32'h3000_0000, 32'd1, 50, rd, lat, seen);
      pushIdx = 0;
      applyStimulus(1'b1, 32'h3000_0080, 32'hA, 50, rd, lat, seen);
      checkOutput("push.lat", lat, 2);
      applyStimulus(1'b1, 32'h3000_0080, 32'hB, 50, rd, lat, seen);
      applyStimulus(1'b1, 32'h3000_0080, 32'hC, 50, rd, lat, seen);
      applyStimulus(1'b1, 32'h3000_0080, 32'hD, 50, rd, lat, seen);
      checkOutput("push.count", pushIdx, 4);
      checkOutput("push.tlast", {pushLast[0], pushLast[1], pushLast[2], pushLast[3]}, 4'b0010);
      checkOutput("push.data", {pushData[0][3:0], pushData[1][3:0], pushData[2][3:0],
                               pushData[3][3:0]}, 16'hABCD);

      // Pop that never gets data: aborted after the wait budget.
      smValid = 1'b0;
      applyStimulus(1'b0, 32'h3000_0084, 32'd0, 400, rd, lat, seen);
      checkOutput("popTimeout.seen", seen, 1);
      checkOutput("popTimeout.lat", lat, 256);
      checkOutput("popTimeout.data", rd, 32'hFFFF_FFFF);
      checkOutput("popTimeout.tready", lastSmTready, 1'b0);

      // Pop with data already waiting.
      smValid = 1'b1; smData = 32'h1234;
      applyStimulus(1'b0, 32'h3000_0084, 32'd0, 50, rd, lat, seen);
      checkOutput("pop.data", rd, 32'h1234);
      checkOutput("pop.lat", lat, 2);
      smValid = 1'b0;

      // Unmapped offsets and a foreign window.
      axiActivity = 0;
      applyStimulus(1'b1, 32'h3000_0100, 32'hDEAD, 50, rd, lat, seen);
      checkOutput("unmappedWr.lat", lat, 1);
      checkOutput("unmappedWr.axi", axiActivity, 0);
      applyStimulus(1'b0, 32'h3000_0080, 32'd0, 50, rd, lat, seen);
      checkOutput("unmappedRd.lat", lat, 1);
      checkOutput("unmappedRd.data", rd, 32'd0);
      axiActivity = 0;
      applyStimulus(1'b0, 32'h3800_0000, 32'd0, 20, rd, lat, seen);
      checkOutput("otherWindow.noAck", seen, 0);
      checkOutput("otherWindow.axi", axiActivity, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
